// File: rtl/result_buffer.sv
// result_buffer: DEPTH-entry show-ahead FIFO between the MAC stage and its consumer.
// Upstream has no backpressure, so a result that arrives while the buffer is full
// and no entry leaves is dropped and latched in the sticky overflow flag.
// All outputs are registered. data_out is precomputed from next-state head.
// Optional feature macro: RESULT_BUFFER_STATS_EN adds max_seen, the largest
// value accepted since reset.
module result_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       validi,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       readyi,
  output logic                       valido,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
`ifdef RESULT_BUFFER_STATS_EN
  ,
  output logic [WIDTH-1:0]           max_seen
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valido_q, valido_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;
  logic             push_s, pop_s, full_s, drop_s;

  // Next-state: push/pop decisions, pointer wrap, occupancy and registered head value.
  always_comb begin
    pop_s  = valido_q & readyi;
    full_s = (count_q == CNT_W'(DEPTH));
    push_s = validi & (~full_s | pop_s);
    drop_s = validi & full_s & ~pop_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q | drop_s;
    valido_d   = (count_d != CNT_W'(0));

    // The head after this edge is either the slot being written now (when it is
    // the only live entry) or an already stored slot.
    if (!valido_d) begin
      data_out_d = WIDTH'(0);
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      data_out_d = data_in;
    end else begin
      data_out_d = mem_q[rd_ptr_d];
    end
  end

  // Control state and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= PTR_W'(0);
      rd_ptr_q   <= PTR_W'(0);
      count_q    <= CNT_W'(0);
      valido_q   <= 1'b0;
      data_out_q <= WIDTH'(0);
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valido_q   <= valido_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are not cleared, pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign valido   = valido_q;
  assign data_out = data_out_q;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef RESULT_BUFFER_STATS_EN
  logic [WIDTH-1:0] max_seen_q, max_seen_d;

  // Track the largest accepted value; dropped inputs never reach push_s.
  always_comb begin
    if (push_s && (data_in > max_seen_q)) begin
      max_seen_d = data_in;
    end else begin
      max_seen_d = max_seen_q;
    end
  end

  // Statistics register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_seen_q <= WIDTH'(0);
    end else begin
      max_seen_q <= max_seen_d;
    end
  end

  assign max_seen = max_seen_q;
`else
  // Statistics disabled: no max_seen port or tracking logic.
`endif

endmodule

// File: tb/tb_result_buffer.sv
// Directed table-driven bench for result_buffer (DEPTH=4, WIDTH=8).
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge that consumed them.
module tb_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       validi;
  logic [7:0] data_in;
  logic       readyi;
  logic       valido;
  logic [7:0] data_out;
  logic [2:0] count;
  logic       overflow;
`ifdef RESULT_BUFFER_STATS_EN
  logic [7:0] max_seen;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic       rst;
    logic       validi;
    logic [7:0] data_in;
    logic       readyi;
    logic       exp_valido;
    logic [7:0] exp_data;
    logic [2:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  result_buffer #(.DEPTH(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .validi   (validi),
    .data_in  (data_in),
    .readyi   (readyi),
    .valido   (valido),
    .data_out (data_out),
    .count    (count),
    .overflow (overflow)
`ifdef RESULT_BUFFER_STATS_EN
    ,
    .max_seen (max_seen)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic [2:0] ec, input logic eo);
    vec_t t;
    t.rst = r; t.validi = v; t.data_in = d; t.readyi = rdy;
    t.exp_valido = ev; t.exp_data = ed; t.exp_count = ec; t.exp_ovf = eo;
    vecs.push_back(t);
  endtask

  // Apply one cycle of stimulus and advance past the consuming edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    rst = r; validi = v; data_in = d; readyi = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; validi = 1'b0; data_in = 8'h00; readyi = 1'b0;

    // reset held with input active
    add(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    // latency and order
    add(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0);
    add(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 3'd3, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 3'd2, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    // overflow: fifth value dropped
    add(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0);
    add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0);
    add(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0);
    add(1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd2, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd1, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1);
    // reset clears sticky overflow
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    // full simultaneous push and pop
    add(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0);
    add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0);
    add(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0);
    add(1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 8'h02, 3'd4, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd3, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd2, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h09, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    // push and pop with count=1
    add(1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 8'h08, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 8'h06, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    // reset mid-stream overrides push and pop, no stale entry afterwards
    add(1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 8'h31, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h32, 1'b0, 1'b1, 8'h31, 3'd2, 1'b0);
    add(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h31, 3'd3, 1'b0);
    add(1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].validi, vecs[i].data_in, vecs[i].readyi);
      chk("valido",   i, {31'd0, valido},   {31'd0, vecs[i].exp_valido});
      chk("data_out", i, {24'd0, data_out}, {24'd0, vecs[i].exp_data});
      chk("count",    i, {29'd0, count},    {29'd0, vecs[i].exp_count});
      chk("overflow", i, {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end

    // overflow stays set through idle, traffic and draining until reset
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i == 2) ? 1'b1 : 1'b0, 8'h60, 1'b1);
      chk("sticky_ovf", i, {31'd0, overflow}, 32'd1);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_cleared", 0, {31'd0, overflow}, 32'd0);

`ifdef RESULT_BUFFER_STATS_EN
    chk("max_reset", 0, {24'd0, max_seen}, 32'd0);
    step(1'b0, 1'b1, 8'd5, 1'b0);
    chk("max_5", 0, {24'd0, max_seen}, 32'd5);
    step(1'b0, 1'b1, 8'd200, 1'b0);
    chk("max_200", 0, {24'd0, max_seen}, 32'd200);
    step(1'b0, 1'b1, 8'd17, 1'b0);
    chk("max_17", 0, {24'd0, max_seen}, 32'd200);
    step(1'b0, 1'b1, 8'd3, 1'b0);
    step(1'b0, 1'b1, 8'd250, 1'b0);
    chk("max_drop", 0, {24'd0, max_seen}, 32'd200);
    chk("drop_ovf", 0, {31'd0, overflow}, 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("max_rst", 0, {24'd0, max_seen}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
